candle_led_driver: RTL and testbench

Downstream stage of `candle_controller`: consumes its 8-bit `candle_state` vector and drives eight physical candle LEDs. Each LED is driven by a per-candle PWM brightness level that ramps up on ignition and down on extinguish, with an optional LFSR flicker on fully lit candles. Status outputs report the number of fully lit candles and whether any ramp is still in progress.

---
 rtl/candle_led_driver_if.sv | 23 ++
 rtl/candle_led_driver.sv | 105 ++++++++++
 tb/tb_candle_led_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/candle_led_driver_if.sv
// Candle LED driver bus: lit mask in, PWM drive and status out.
interface candle_led_driver_if;
  logic [7:0] candle_state;
  logic [7:0] led_out;
  logic [3:0] lit_count;
  logic       busy;

  // Master drives the lit mask and observes the LED side
  modport master (
    output candle_state,
    input  led_out,
    input  lit_count,
    input  busy
  );

  // Slave is the driver itself
  modport slave (
    input  candle_state,
    output led_out,
    output lit_count,
    output busy
  );
endinterface

// File: rtl/candle_led_driver.sv
// Candle LED driver: per-candle brightness ramps toward the lit mask one
// level per prescaler step, rendered as PWM with optional LFSR flicker.
module candle_led_driver #(
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned STEP_DIV   = 1000,
  parameter int unsigned FLICKER_EN = 1
) (
  input  logic               sys_clk,
  input  logic               clr_async,
  candle_led_driver_if.slave bus
);

  localparam int unsigned     PS_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [7:0]          r_state_q;
  logic [PS_W-1:0]     r_presc;
  logic [PWM_BITS-1:0] r_b [8];
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [7:0]          r_lfsr;
  logic [7:0]          r_led_out;
  logic [3:0]          r_lit_count;
  logic                r_busy;

  logic                w_step_tick;
  logic                w_lfsr_fb;
  logic [7:0]          w_lfsr_rot;
  logic [7:0]          w_flicker;
  logic [PWM_BITS-1:0] w_eff [8];
  logic [7:0]          w_led_nxt;
  logic [3:0]          w_lit_nxt;
  logic                w_busy_nxt;

  assign w_step_tick = (r_presc == PS_LAST);
  // Taps for x^8+x^6+x^5+x^4+1
  assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // Bit i of the rotated copy is lfsr[(i+3)%8], the flicker partner bit
  assign w_lfsr_rot  = {r_lfsr[2:0], r_lfsr[7:3]};
  assign w_flicker   = (FLICKER_EN != 0) ? (r_lfsr & w_lfsr_rot) : 8'h00;

  // Input register, prescaler, PWM counter and LFSR
  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      r_state_q <= '0;
      r_presc   <= '0;
      r_pwm_cnt <= '0;
      r_lfsr    <= 8'hA5;
    end else begin
      r_state_q <= bus.candle_state;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_step_tick) begin
        r_presc <= '0;
        r_lfsr  <= {r_lfsr[6:0], w_lfsr_fb};
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Brightness: one saturating level toward the target on each step tick
  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      for (int unsigned i = 0; i < 8; i++) r_b[i] <= '0;
    end else if (w_step_tick) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (r_state_q[i] && (r_b[i] != MAX))
          r_b[i] <= r_b[i] + 1'b1;
        else if (!r_state_q[i] && (r_b[i] != '0))
          r_b[i] <= r_b[i] - 1'b1;
      end
    end
  end

  // Effective brightness, PWM compare and status terms
  always_comb begin
    w_led_nxt  = '0;
    w_lit_nxt  = '0;
    w_busy_nxt = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_eff[i] = ((r_b[i] == MAX) && w_flicker[i]) ? (MAX - 1'b1) : r_b[i];
      w_led_nxt[i] = (w_eff[i] == MAX) || (w_eff[i] > r_pwm_cnt);
      if (r_b[i] == MAX) w_lit_nxt = w_lit_nxt + 4'd1;
      if (r_state_q[i] ? (r_b[i] != MAX) : (r_b[i] != '0)) w_busy_nxt = 1'b1;
    end
  end

  // Registered outputs
  always_ff @(posedge sys_clk or posedge clr_async) begin
    if (clr_async) begin
      r_led_out   <= '0;
      r_lit_count <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_led_out   <= w_led_nxt;
      r_lit_count <= w_lit_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.led_out   = r_led_out;
  assign bus.lit_count = r_lit_count;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_candle_led_driver.sv
// Bench for candle_led_driver: a steady and a flickering instance share
// stimulus; a reference model queues expected outputs, a monitor checks them.
module tb_candle_led_driver;

  localparam int SD  = 4;
  localparam int MX  = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cs  = 8'hFF;

  candle_led_driver_if bus0 ();
  candle_led_driver_if bus1 ();
  assign bus0.candle_state = cs;
  assign bus1.candle_state = cs;

  candle_led_driver #(.PWM_BITS(4), .STEP_DIV(SD), .FLICKER_EN(0)) dut_steady (
    .sys_clk(clk), .clr_async(rst), .bus(bus0.slave)
  );
  candle_led_driver #(.PWM_BITS(4), .STEP_DIV(SD), .FLICKER_EN(1)) dut_flicker (
    .sys_clk(clk), .clr_async(rst), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led0;
    logic [7:0] led1;
    logic [3:0] lit0;
    logic [3:0] lit1;
    logic       busy0;
    logic       busy1;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
  endtask

  // Reference model: brightness levels, time since reset and the flicker LFSR
  int unsigned m_c;
  logic [7:0]  m_sq;
  int          m_b [8];
  logic [7:0]  m_lfsr;

  always @(posedge clk) begin
    exp_t e;
    int   pwm, tgt, e1;
    e = '0;
    if (rst) begin
      m_c = 0; m_sq = 8'h00; m_lfsr = 8'hA5;
      for (int i = 0; i < 8; i++) m_b[i] = 0;
    end else begin
      pwm = int'(m_c % 16);
      for (int i = 0; i < 8; i++) begin
        tgt = m_sq[i] ? MX : 0;
        e1  = (m_b[i] == MX && m_lfsr[i] && m_lfsr[(i + 3) % 8]) ? MX - 1 : m_b[i];
        e.led0[i] = (m_b[i] == MX) || (m_b[i] > pwm);
        e.led1[i] = (e1 == MX) || (e1 > pwm);
        if (m_b[i] == MX) begin e.lit0 = e.lit0 + 1; e.lit1 = e.lit1 + 1; end
        if (m_b[i] != tgt) begin e.busy0 = 1'b1; e.busy1 = 1'b1; end
      end
      if (m_c % SD == SD - 1) begin
        for (int i = 0; i < 8; i++) begin
          tgt = m_sq[i] ? MX : 0;
          if (tgt > m_b[i]) m_b[i] = m_b[i] + 1;
          else if (tgt < m_b[i]) m_b[i] = m_b[i] - 1;
        end
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      end
      m_sq = cs;
      m_c++;
    end
    q.push_back(e);
  end

  // Monitor: one expectation per cycle, reset forces all-zero outputs
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    ok = 1'b1;
    e  = '0;
    if (q.size() == 0) begin
      if (!rst) begin
        check("sb_depth", q.size(), 1);
        ok = 1'b0;
      end
    end else begin
      e = q.pop_front();
    end
    if (rst) e = '0;
    if (ok) begin
      check("led_out_steady",    bus0.led_out,   e.led0);
      check("lit_count_steady",  bus0.lit_count, e.lit0);
      check("busy_steady",       bus0.busy,      e.busy0);
      check("led_out_flicker",   bus1.led_out,   e.led1);
      check("lit_count_flicker", bus1.lit_count, e.lit1);
      check("busy_flicker",      bus1.busy,      e.busy1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset with all candles requested, released with none
    rst = 1'b1; cs = 8'hFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; cs = 8'h00;
    cyc(6);

    // Single ignition and full ramp
    cs = 8'h08;
    cyc(70);

    // Extinguish, relight, reverse at level 7
    cs = 8'h00;
    cyc(70);
    cs = 8'h08;
    k = 0;
    while (m_b[3] != 7 && k < 200) begin cyc(1); k++; end
    check("reach_b3_7", m_b[3], 7);
    cs = 8'h00;
    cyc(40);

    // Simultaneous ignition
    cs = 8'hFF;
    cyc(70);

    // Async reset mid-ramp at level 5
    cs = 8'h00;
    cyc(70);
    cs = 8'hFF;
    k = 0;
    while (m_b[0] != 5 && k < 200) begin cyc(1); k++; end
    check("reach_b0_5", m_b[0], 5);
    #1 rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(40);

    // Random masks, sub-tick glitches and long holds
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin cs = 8'($urandom); cyc($urandom_range(1, 40)); end
        1: begin
             logic [7:0] keep;
             keep = cs;
             cs = 8'($urandom);
             cyc($urandom_range(1, 2));
             cs = keep;
             cyc($urandom_range(1, 10));
           end
        2: begin cs = 8'hFF; cyc(80); end
        default: begin cs = cs ^ (8'h01 << $urandom_range(0, 7)); cyc($urandom_range(5, 30)); end
      endcase
    end

    // All lit long enough for the LFSR to cycle through its full period
    cs = 8'hFF;
    cyc(1100);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
